// File: rtl/l1ca_acq_scheduler.sv
// Acquisition sweep controller: walks the SV mask, drives the L1 C/A search engine one SV
// at a time, and streams any result whose peak power exceeds the threshold.
module l1ca_acq_scheduler #(
    parameter int N_SV          = 32,
    parameter int START_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              abort,
    input  logic [N_SV-1:0]   sv_mask,
    input  logic [31:0]       threshold,
    output logic              search_start,
    output logic [4:0]        search_sv,
    input  logic              search_busy,
    input  logic [31:0]       search_acc,
    input  logic [11:0]       search_code,
    input  logic [4:0]        search_dop,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [4:0]        res_sv,
    output logic [11:0]       res_code,
    output logic [4:0]        res_dop,
    output logic [31:0]       res_acc,
    output logic              busy,
    output logic              done,
    output logic [5:0]        found_cnt,
    output logic              timeout_err,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SCAN      = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_EVAL      = 3'd5;
    localparam logic [2:0] S_PUSH      = 3'd6;
    localparam logic [2:0] S_FINISH    = 3'd7;

    localparam logic [4:0] LAST_SLOT = 5'(N_SV - 1);
    localparam logic [2:0] TMO_LAST  = 3'(START_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  sv_q, sv_d;
    logic [2:0]  tmo_q, tmo_d;
    logic [5:0]  found_q, found_d;
    logic        terr_q, terr_d;
    logic        abort_q, abort_d;
    logic [4:0]  rsv_q, rsv_d;
    logic [11:0] rcode_q, rcode_d;
    logic [4:0]  rdop_q, rdop_d;
    logic [31:0] racc_q, racc_d;
    logic        advance;

    // Handshake: a record transfers on any cycle where res_valid and res_ready are both high;
    // res_valid only drops after that transfer, and res_* hold steady while it is up.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sv_d    = sv_q;
        tmo_d   = tmo_q;
        found_d = found_q;
        terr_d  = terr_q;
        abort_d = abort_q | (abort && (state_q != S_IDLE));
        rsv_d   = rsv_q;
        rcode_d = rcode_q;
        rdop_d  = rdop_q;
        racc_d  = racc_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    found_d = '0;
                    terr_d  = 1'b0;
                    abort_d = 1'b0;
                    ptr_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort_d) begin
                    state_d = S_FINISH;
                end else if (sv_mask[ptr_q]) begin
                    sv_d    = ptr_q;
                    state_d = S_LAUNCH;
                end else if (ptr_q == LAST_SLOT) begin
                    state_d = S_FINISH;
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (search_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    terr_d  = 1'b1;
                    advance = 1'b1;
                end else begin
                    tmo_d = tmo_q + 3'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!search_busy) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (search_acc > threshold) begin
                    rsv_d   = sv_q;
                    rcode_d = search_code;
                    rdop_d  = search_dop;
                    racc_d  = search_acc;
                    state_d = S_PUSH;
                end else begin
                    advance = 1'b1;
                end
            end
            S_PUSH: begin
                if (res_ready) begin
                    if (found_q != 6'd63) found_d = found_q + 6'd1;
                    advance = 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Shared exit of a completed slot: an abort seen during the search lands here.
        if (advance) begin
            if (abort_d || (ptr_q == LAST_SLOT)) begin
                state_d = S_FINISH;
            end else begin
                ptr_d   = ptr_q + 5'd1;
                state_d = S_SCAN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sv_q    <= '0;
            tmo_q   <= '0;
            found_q <= '0;
            terr_q  <= 1'b0;
            abort_q <= 1'b0;
            rsv_q   <= '0;
            rcode_q <= '0;
            rdop_q  <= '0;
            racc_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sv_q    <= sv_d;
            tmo_q   <= tmo_d;
            found_q <= found_d;
            terr_q  <= terr_d;
            abort_q <= abort_d;
            rsv_q   <= rsv_d;
            rcode_q <= rcode_d;
            rdop_q  <= rdop_d;
            racc_q  <= racc_d;
        end
    end

    assign search_start = (state_q == S_LAUNCH);
    assign search_sv    = sv_q;
    assign res_valid    = (state_q == S_PUSH);
    assign res_sv       = rsv_q;
    assign res_code     = rcode_q;
    assign res_dop      = rdop_q;
    assign res_acc      = racc_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign found_cnt    = found_q;
    assign timeout_err  = terr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_l1ca_acq_scheduler.sv
// Directed bench for l1ca_acq_scheduler with a behavioural search-engine model and sweep scoreboard.
module tb_l1ca_acq_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] sv_mask = '0;
    logic [31:0] threshold = '0;
    logic        search_start;
    logic [4:0]  search_sv;
    logic        search_busy = 1'b0;
    logic [31:0] search_acc = '0;
    logic [11:0] search_code = '0;
    logic [4:0]  search_dop = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [4:0]  res_sv;
    logic [11:0] res_code;
    logic [4:0]  res_dop;
    logic [31:0] res_acc;
    logic        busy;
    logic        done;
    logic [5:0]  found_cnt;
    logic        timeout_err;
    logic [2:0]  dbg_state;

    l1ca_acq_scheduler #(.N_SV(32), .START_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort),
        .sv_mask(sv_mask), .threshold(threshold),
        .search_start(search_start), .search_sv(search_sv),
        .search_busy(search_busy), .search_acc(search_acc),
        .search_code(search_code), .search_dop(search_dop),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sv(res_sv), .res_code(res_code), .res_dop(res_dop), .res_acc(res_acc),
        .busy(busy), .done(done), .found_cnt(found_cnt),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- counters and check helper ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- engine responses (per SV) ----------------
    logic        resp_ok   [32];
    int          resp_len  [32];
    logic [31:0] resp_acc  [32];
    logic [11:0] resp_code [32];
    logic [4:0]  resp_dop  [32];
    int          start_cnt = 0;

    task automatic clear_resp();
        for (int k = 0; k < 32; k++) begin
            resp_ok[k] = 1'b1; resp_len[k] = 5;
            resp_acc[k] = '0; resp_code[k] = '0; resp_dop[k] = '0;
        end
    endtask

    task automatic set_resp(input int k, input logic ok, input logic [31:0] acc,
                            input logic [11:0] code, input logic [4:0] dop);
        resp_ok[k] = ok; resp_acc[k] = acc; resp_code[k] = code; resp_dop[k] = dop;
    endtask

    // Engine: busy rises the cycle after start, stays up resp_len cycles, results appear as it falls.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && search_start === 1'b1) begin
                int k;
                start_cnt++;
                k = int'(search_sv);
                if (resp_ok[k]) begin
                    @(posedge clk); #1 search_busy = 1'b1;
                    repeat (resp_len[k]) @(posedge clk);
                    #1;
                    search_acc  = resp_acc[k];
                    search_code = resp_code[k];
                    search_dop  = resp_dop[k];
                    search_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- sweep model / scoreboard ----------------
    logic [53:0] exp_q[$];
    logic [4:0]  launch_q[$];
    int          exp_found = 0;
    logic        exp_terr = 1'b0;
    logic [53:0] last_rec = '0;

    // Expected sweep outcome: every masked SV in ascending order is searched (up to the one
    // during which abort arrives); a responding SV whose power strictly beats the threshold
    // yields one record; a silent SV only raises the timeout flag.
    task automatic plan(input logic [31:0] mask, input logic [31:0] thr, input int abort_sv);
        exp_q.delete(); launch_q.delete();
        exp_found = 0; exp_terr = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (mask[k]) begin
                launch_q.push_back(5'(k));
                if (!resp_ok[k]) exp_terr = 1'b1;
                else if (resp_acc[k] > thr) begin
                    exp_q.push_back({5'(k), resp_code[k], resp_dop[k], resp_acc[k]});
                    if (exp_found < 63) exp_found++;
                end
                if (k == abort_sv) break;
            end
        end
    endtask

    logic        held_q = 1'b0;
    logic [53:0] prev_rec = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                held_q = 1'b0;
            end else begin
                logic [53:0] rec;
                rec = {res_sv, res_code, res_dop, res_acc};
                if (search_start) begin
                    if (launch_q.size() == 0) chk("unexpected_start", 64'(search_sv), 64'h1f_ffff);
                    else chk("start_sv", 64'(search_sv), 64'(launch_q.pop_front()));
                end
                if (res_valid) begin
                    if (held_q) chk("rec_stable", 64'(rec), 64'(prev_rec));
                    if (res_ready) begin
                        last_rec = rec;
                        if (exp_q.size() == 0) chk("unexpected_rec", 64'(rec), 64'h3f_ffff_ffff_ffff);
                        else chk("rec", 64'(rec), 64'(exp_q.pop_front()));
                    end
                end
                held_q   = res_valid && !res_ready;
                prev_rec = rec;
                if (done) begin
                    chk("done_found_cnt", 64'(found_cnt), 64'(exp_found));
                    chk("done_timeout_err", 64'(timeout_err), 64'(exp_terr));
                    chk("done_recs_left", 64'(exp_q.size()), 64'd0);
                    chk("done_starts_left", 64'(launch_q.size()), 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_sweep(input logic [31:0] mask, input logic [31:0] thr, input int abort_sv);
        start_cnt = 0;
        plan(mask, thr, abort_sv);
        sv_mask = mask; threshold = thr;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        logic got;
        got = 1'b0; cycles = 0;
        while (!got && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int  cyc;
        logic hit;
        logic saw_busy;
        int  s0;
        clear_resp();
        repeat (2) @(negedge clk);
        chk("reset_a", {search_start, search_sv, res_valid, res_sv, res_code, res_dop}, 64'd0);
        chk("reset_b", {res_acc, busy, done, found_cnt, timeout_err}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Two searches, one detection
        clear_resp();
        set_resp(0, 1'b1, 32'd5000, 12'd123, 5'd7);
        set_resp(2, 1'b1, 32'd500, 12'd55, 5'd3);
        start_sweep(32'h0000_0005, 32'd1000, -1);
        wait_done(cyc);
        chk("t1_found", 64'(found_cnt), 64'd1);
        chk("t1_starts", 64'(start_cnt), 64'd2);
        chk("t1_rec", 64'(last_rec), {10'd0, 5'd0, 12'd123, 5'd7, 32'd5000});

        // Threshold boundary
        clear_resp();
        set_resp(0, 1'b1, 32'd1000, 12'd9, 5'd1);
        start_sweep(32'h1, 32'd1000, -1);
        wait_done(cyc);
        chk("t2_equal_found", 64'(found_cnt), 64'd0);
        set_resp(0, 1'b1, 32'd1001, 12'd9, 5'd1);
        start_sweep(32'h1, 32'd1000, -1);
        wait_done(cyc);
        chk("t2_above_rec", 64'(last_rec), {10'd0, 5'd0, 12'd9, 5'd1, 32'd1001});

        // Backpressure
        clear_resp();
        set_resp(0, 1'b1, 32'hdead_beef, 12'd4000, 5'd20);
        set_resp(1, 1'b1, 32'd2000, 12'd1, 5'd2);
        res_ready = 1'b0;
        start_sweep(32'h3, 32'd1000, -1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (res_valid) hit = 1'b1;
        end
        chk("t3_valid_seen", 64'(hit), 64'd1);
        repeat (50) @(negedge clk);
        chk("t3_hold_valid", 64'(res_valid), 64'd1);
        chk("t3_hold_starts", 64'(start_cnt), 64'd1);
        @(posedge clk); #1 res_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t3_next_launch", 64'(start_cnt), 64'd2);
        wait_done(cyc);
        chk("t3_found", 64'(found_cnt), 64'd2);

        // Engine never goes busy on SV1
        clear_resp();
        set_resp(1, 1'b0, 32'd0, 12'd0, 5'd0);
        set_resp(2, 1'b1, 32'd7000, 12'd4091, 5'd20);
        start_sweep(32'h6, 32'd1000, -1);
        wait_done(cyc);
        chk("t4_terr", 64'(timeout_err), 64'd1);
        chk("t4_rec", 64'(last_rec), {10'd0, 5'd2, 12'd4091, 5'd20, 32'd7000});

        // Abort during the search of SV3
        clear_resp();
        set_resp(1, 1'b1, 32'd2000, 12'd11, 5'd4);
        set_resp(3, 1'b1, 32'd3000, 12'd33, 5'd6);
        start_sweep(32'hFFFF_FFFF, 32'd1000, 3);
        chk("t5_run_clears_terr", 64'(timeout_err), 64'd0);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (search_busy && search_sv == 5'd3) hit = 1'b1;
        end
        chk("t5_abort_sync", 64'(hit), 64'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done(cyc);
        chk("t5_starts", 64'(start_cnt), 64'd4);
        chk("t5_found", 64'(found_cnt), 64'd2);
        start_sweep(32'h0, 32'd1000, -1);
        @(negedge clk);
        chk("t5_rerun_clears", 64'(found_cnt), 64'd0);
        wait_done(cyc);
        chk("t5_empty_cycles", 64'(cyc + 1), 64'd33);

        // Reset while waiting for the engine
        clear_resp();
        resp_len[0] = 20;
        start_sweep(32'h1, 32'd0, -1);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (search_busy) hit = 1'b1;
        end
        chk("t6_busy_seen", 64'(hit), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_reset_a", {search_start, search_sv, res_valid, res_sv, res_code, res_dop}, 64'd0);
        chk("t6_reset_b", {res_acc, busy, done, found_cnt, timeout_err}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete(); launch_q.delete();
        s0 = start_cnt;
        saw_busy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (busy || res_valid || done) saw_busy = 1'b1;
        end
        chk("t6_engine_fell", 64'(search_busy), 64'd0);
        chk("t6_stays_idle", 64'(saw_busy), 64'd0);
        chk("t6_no_start", 64'(start_cnt), 64'(s0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
